secuenciador_servicio: RTL and testbench

Dispense sequencer for the coffee machine. It takes a single serve request from the main vending FSM once payment is settled and drives the shared heater, water pump and coffee doser through a fixed, timed sequence. When the drink is finished or a fault is found, it reports back with a one-cycle completion pulse and an error code. It owns the physical actuators, so the vending FSM never toggles them directly.

---
 rtl/secuenciador_servicio.sv | 168 ++++++++++++++++
 tb/tb_secuenciador_servicio.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_servicio.sv
// Dispense sequencer: takes one serve request from the vending FSM, runs the
// heater / doser / pump through a timed sequence and reports completion with
// a one-cycle pulse and a result code.
module secuenciador_servicio #(
  parameter int W           = 8,
  parameter int T_CAL_MAX   = 20,
  parameter int T_DOSIS     = 4,
  parameter int T_AGUA_CAFE = 8,
  parameter int T_AGUA_TE   = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       tipo,
  input  logic       ha,
  input  logic       hc,
  input  logic       temp_ok,
  output logic       calentador,
  output logic       dosificador,
  output logic       bomba,
  output logic       ocupado,
  output logic       listo,
  output logic [1:0] error
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    HEAT  = 3'd2,
    DOSE  = 3'd3,
    POUR  = 3'd4,
    DONE  = 3'd5
  } estado_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_AGUA    = 2'b01;
  localparam logic [1:0] ERR_CAFE    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // Counter loads are N-1 so a phase lasts exactly N cycles, exiting on count 0.
  localparam logic [W-1:0] CARGA_CAL   = W'(T_CAL_MAX - 1);
  localparam logic [W-1:0] CARGA_DOSIS = W'(T_DOSIS - 1);
  localparam logic [W-1:0] CARGA_CAFE  = W'(T_AGUA_CAFE - 1);
  localparam logic [W-1:0] CARGA_TE    = W'(T_AGUA_TE - 1);

  estado_t        estado, estado_nxt;
  logic [W-1:0]   cnt, cnt_nxt;
  logic           tipo_q, tipo_nxt;
  logic [1:0]     error_q, error_nxt;

  // State and result-code registers; reset returns to IDLE with a clean code.
  always_ff @(posedge clk) begin
    if (!rst) begin
      estado  <= IDLE;
      error_q <= ERR_OK;
    end else begin
      estado  <= estado_nxt;
      error_q <= error_nxt;
    end
  end

  // Timer and latched drink type; always loaded before use, so no reset needed.
  always_ff @(posedge clk) begin
    cnt    <= cnt_nxt;
    tipo_q <= tipo_nxt;
  end

  // Next-state, timer and result-code decisions.
  always_comb begin
    estado_nxt = estado;
    cnt_nxt    = cnt;
    tipo_nxt   = tipo_q;
    error_nxt  = error_q;
    case (estado)
      IDLE: begin
        if (req) begin
          tipo_nxt   = tipo;
          error_nxt  = ERR_OK;
          estado_nxt = CHECK;
        end
      end
      CHECK: begin
        if (!ha) begin
          error_nxt  = ERR_AGUA;
          estado_nxt = DONE;
        end else if (!tipo_q && !hc) begin
          error_nxt  = ERR_CAFE;
          estado_nxt = DONE;
        end else begin
          cnt_nxt    = CARGA_CAL;
          estado_nxt = HEAT;
        end
      end
      HEAT: begin
        // Reaching temperature wins over a timeout on the same cycle.
        if (temp_ok) begin
          if (!tipo_q) begin
            cnt_nxt    = CARGA_DOSIS;
            estado_nxt = DOSE;
          end else begin
            cnt_nxt    = CARGA_TE;
            estado_nxt = POUR;
          end
        end else if (cnt == '0) begin
          error_nxt  = ERR_TIMEOUT;
          estado_nxt = DONE;
        end else begin
          cnt_nxt = cnt - W'(1);
        end
      end
      DOSE: begin
        // Coffee loss after CHECK is deliberately ignored; only water aborts.
        if (!ha) begin
          error_nxt  = ERR_AGUA;
          estado_nxt = DONE;
        end else if (cnt == '0) begin
          cnt_nxt    = CARGA_CAFE;
          estado_nxt = POUR;
        end else begin
          cnt_nxt = cnt - W'(1);
        end
      end
      POUR: begin
        if (!ha) begin
          error_nxt  = ERR_AGUA;
          estado_nxt = DONE;
        end else if (cnt == '0) begin
          estado_nxt = DONE;
        end else begin
          cnt_nxt = cnt - W'(1);
        end
      end
      DONE: begin
        estado_nxt = IDLE;
      end
      default: begin
        estado_nxt = IDLE;
      end
    endcase
  end

  // Actuator and status outputs decoded purely from the registered state.
  always_comb begin
    calentador  = 1'b0;
    dosificador = 1'b0;
    bomba       = 1'b0;
    ocupado     = 1'b1;
    listo       = 1'b0;
    case (estado)
      IDLE:  ocupado = 1'b0;
      CHECK: ;
      HEAT:  calentador = 1'b1;
      DOSE: begin
        calentador  = 1'b1;
        dosificador = 1'b1;
      end
      POUR: begin
        calentador = 1'b1;
        bomba      = 1'b1;
      end
      DONE:  listo = 1'b1;
      default: ocupado = 1'b0;
    endcase
  end

  assign error = error_q;

endmodule

// File: tb/tb_secuenciador_servicio.sv
// Directed bench for the dispense sequencer. Cycle c=0 is the cycle right
// after the edge that accepted the request (the CHECK cycle).
module tb_secuenciador_servicio;

  logic       clk = 1'b0;
  logic       rst, req, tipo, ha, hc, temp_ok;
  logic       calentador, dosificador, bomba, ocupado, listo;
  logic [1:0] error;

  int errors = 0;
  int checks = 0;

  bit       lg_cal [0:63];
  bit       lg_dos [0:63];
  bit       lg_bom [0:63];
  bit       lg_ocu [0:63];
  bit       lg_lis [0:63];
  bit [1:0] lg_err [0:63];
  int n_cal, n_dos, n_bom, n_listo, first_dos, first_bom, listo_at, both;

  secuenciador_servicio dut (
    .clk(clk), .rst(rst), .req(req), .tipo(tipo), .ha(ha), .hc(hc),
    .temp_ok(temp_ok), .calentador(calentador), .dosificador(dosificador),
    .bomba(bomba), .ocupado(ocupado), .listo(listo), .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request; it is sampled at the next edge.
  task automatic accept(input logic t, input logic hold);
    tipo = t;
    req  = 1'b1;
    step();
    if (!hold) req = 1'b0;
  endtask

  // Record outputs for n cycles, applying input events at given cycles.
  task automatic observe(input int n, input int tok_at, input int ha_off_at,
                         input int rst_at, input int req_off_at);
    n_cal = 0; n_dos = 0; n_bom = 0; n_listo = 0;
    first_dos = -1; first_bom = -1; listo_at = -1; both = 0;
    for (int c = 0; c < n; c++) begin
      if (c == tok_at) temp_ok = 1'b1;
      if (c == ha_off_at) ha = 1'b0;
      if (c == rst_at) rst = 1'b0;
      if (rst_at >= 0 && c == rst_at + 1) rst = 1'b1;
      if (c == req_off_at) req = 1'b0;
      lg_cal[c] = calentador; lg_dos[c] = dosificador; lg_bom[c] = bomba;
      lg_ocu[c] = ocupado; lg_lis[c] = listo; lg_err[c] = error;
      if (calentador) n_cal++;
      if (dosificador) begin n_dos++; if (first_dos < 0) first_dos = c; end
      if (bomba) begin n_bom++; if (first_bom < 0) first_bom = c; end
      if (listo) begin n_listo++; if (listo_at < 0) listo_at = c; end
      if (dosificador && bomba) both++;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 1'b0; tipo = 1'b0; ha = 1'b1; hc = 1'b1; temp_ok = 1'b1;
    repeat (3) step();
    checks++; if ({calentador, dosificador, bomba, ocupado, listo, error} !== 7'd0) begin errors++; $display("FAIL reset_outputs got=%b exp=0000000", {calentador, dosificador, bomba, ocupado, listo, error}); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_coffee();
    ha = 1'b1; hc = 1'b1; temp_ok = 1'b1;
    accept(1'b0, 1'b0);
    observe(18, -1, -1, -1, -1);
    checks++; if (lg_ocu[0] !== 1'b1) begin errors++; $display("FAIL coffee_ocupado_c0 got=%0d exp=1", lg_ocu[0]); end
    checks++; if (first_dos !== 2) begin errors++; $display("FAIL coffee_first_dos got=%0d exp=2", first_dos); end
    checks++; if (n_dos !== 4) begin errors++; $display("FAIL coffee_n_dos got=%0d exp=4", n_dos); end
    checks++; if (first_bom !== 6) begin errors++; $display("FAIL coffee_first_bom got=%0d exp=6", first_bom); end
    checks++; if (n_bom !== 8) begin errors++; $display("FAIL coffee_n_bom got=%0d exp=8", n_bom); end
    checks++; if (listo_at !== 14) begin errors++; $display("FAIL coffee_listo_at got=%0d exp=14", listo_at); end
    checks++; if (n_listo !== 1) begin errors++; $display("FAIL coffee_n_listo got=%0d exp=1", n_listo); end
    checks++; if (n_cal !== 13) begin errors++; $display("FAIL coffee_n_cal got=%0d exp=13", n_cal); end
    checks++; if (both !== 0) begin errors++; $display("FAIL coffee_dos_and_bom got=%0d exp=0", both); end
    checks++; if (lg_err[17] !== 2'b00) begin errors++; $display("FAIL coffee_error got=%0d exp=0", lg_err[17]); end
  endtask

  task automatic test_tea();
    ha = 1'b1; hc = 1'b0; temp_ok = 1'b0;
    accept(1'b1, 1'b0);
    observe(24, 6, -1, -1, -1);
    checks++; if (n_dos !== 0) begin errors++; $display("FAIL tea_n_dos got=%0d exp=0", n_dos); end
    checks++; if (first_bom !== 7) begin errors++; $display("FAIL tea_first_bom got=%0d exp=7", first_bom); end
    checks++; if (n_bom !== 12) begin errors++; $display("FAIL tea_n_bom got=%0d exp=12", n_bom); end
    checks++; if (n_cal !== 18) begin errors++; $display("FAIL tea_n_cal got=%0d exp=18", n_cal); end
    checks++; if (listo_at !== 19) begin errors++; $display("FAIL tea_listo_at got=%0d exp=19", listo_at); end
    checks++; if (lg_err[23] !== 2'b00) begin errors++; $display("FAIL tea_error got=%0d exp=0", lg_err[23]); end
    hc = 1'b1; temp_ok = 1'b1;
  endtask

  task automatic test_no_water();
    ha = 1'b0;
    accept(1'b0, 1'b0);
    observe(6, -1, -1, -1, -1);
    checks++; if (listo_at !== 1) begin errors++; $display("FAIL nowater_listo_at got=%0d exp=1", listo_at); end
    checks++; if (n_cal + n_dos + n_bom !== 0) begin errors++; $display("FAIL nowater_actuators got=%0d exp=0", n_cal + n_dos + n_bom); end
    checks++; if (lg_err[5] !== 2'b01) begin errors++; $display("FAIL nowater_error got=%0d exp=1", lg_err[5]); end
    ha = 1'b1;
  endtask

  task automatic test_no_coffee();
    hc = 1'b0;
    accept(1'b0, 1'b0);
    observe(6, -1, -1, -1, -1);
    checks++; if (listo_at !== 1) begin errors++; $display("FAIL nocoffee_listo_at got=%0d exp=1", listo_at); end
    checks++; if (n_cal !== 0) begin errors++; $display("FAIL nocoffee_n_cal got=%0d exp=0", n_cal); end
    checks++; if (lg_err[5] !== 2'b10) begin errors++; $display("FAIL nocoffee_error got=%0d exp=2", lg_err[5]); end
    hc = 1'b1;
  endtask

  task automatic test_timeout();
    temp_ok = 1'b0;
    accept(1'b0, 1'b0);
    observe(26, -1, -1, -1, -1);
    checks++; if (n_cal !== 20) begin errors++; $display("FAIL timeout_n_cal got=%0d exp=20", n_cal); end
    checks++; if (lg_cal[21] !== 1'b0) begin errors++; $display("FAIL timeout_cal_off got=%0d exp=0", lg_cal[21]); end
    checks++; if (listo_at !== 21) begin errors++; $display("FAIL timeout_listo_at got=%0d exp=21", listo_at); end
    checks++; if (n_dos + n_bom !== 0) begin errors++; $display("FAIL timeout_dos_bom got=%0d exp=0", n_dos + n_bom); end
    checks++; if (lg_err[25] !== 2'b11) begin errors++; $display("FAIL timeout_error got=%0d exp=3", lg_err[25]); end
    temp_ok = 1'b1;
  endtask

  task automatic test_water_lost();
    accept(1'b0, 1'b0);
    observe(14, -1, 8, -1, -1);
    checks++; if (n_bom !== 3) begin errors++; $display("FAIL waterlost_n_bom got=%0d exp=3", n_bom); end
    checks++; if (lg_bom[9] !== 1'b0) begin errors++; $display("FAIL waterlost_bom_off got=%0d exp=0", lg_bom[9]); end
    checks++; if (listo_at !== 9) begin errors++; $display("FAIL waterlost_listo_at got=%0d exp=9", listo_at); end
    checks++; if (lg_err[9] !== 2'b01) begin errors++; $display("FAIL waterlost_error got=%0d exp=1", lg_err[9]); end
    ha = 1'b1;
  endtask

  task automatic test_reset_mid_pour();
    // error is 01 from the previous service; an idle reset must clear it
    rst = 1'b0;
    step();
    rst = 1'b1;
    checks++; if (error !== 2'b00) begin errors++; $display("FAIL rstidle_error got=%0d exp=0", error); end
    accept(1'b0, 1'b0);
    observe(14, -1, -1, 8, -1);
    checks++; if (lg_bom[8] !== 1'b1) begin errors++; $display("FAIL rstpour_bom_before got=%0d exp=1", lg_bom[8]); end
    checks++; if ({lg_cal[9], lg_dos[9], lg_bom[9], lg_ocu[9], lg_lis[9], lg_err[9]} !== 7'd0) begin errors++; $display("FAIL rstpour_outputs got=%b exp=0000000", {lg_cal[9], lg_dos[9], lg_bom[9], lg_ocu[9], lg_lis[9], lg_err[9]}); end
    checks++; if (n_listo !== 0) begin errors++; $display("FAIL rstpour_n_listo got=%0d exp=0", n_listo); end
    checks++; if (lg_ocu[13] !== 1'b0) begin errors++; $display("FAIL rstpour_stays_idle got=%0d exp=0", lg_ocu[13]); end
  endtask

  task automatic test_back_to_back();
    temp_ok = 1'b1;
    accept(1'b1, 1'b1);
    observe(34, -1, -1, -1, 31);
    checks++; if (n_listo !== 2) begin errors++; $display("FAIL b2b_n_listo got=%0d exp=2", n_listo); end
    checks++; if (listo_at !== 14) begin errors++; $display("FAIL b2b_listo_first got=%0d exp=14", listo_at); end
    checks++; if (lg_lis[30] !== 1'b1) begin errors++; $display("FAIL b2b_listo_second got=%0d exp=1", lg_lis[30]); end
    checks++; if (lg_ocu[15] !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap got=%0d exp=0", lg_ocu[15]); end
    checks++; if (lg_ocu[16] !== 1'b1) begin errors++; $display("FAIL b2b_reaccept got=%0d exp=1", lg_ocu[16]); end
    checks++; if (n_bom !== 24) begin errors++; $display("FAIL b2b_n_bom got=%0d exp=24", n_bom); end
    checks++; if (lg_ocu[32] !== 1'b0) begin errors++; $display("FAIL b2b_no_third got=%0d exp=0", lg_ocu[32]); end
  endtask

  initial begin
    test_reset();
    test_coffee();
    test_tea();
    test_no_water();
    test_no_coffee();
    test_timeout();
    test_water_lost();
    test_reset_mid_pour();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
